// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_e;

  typedef enum logic {ST_IDLE, ST_LOCKED} lock_state_e;

  // Modular increment: ptr in [0, n-1] -> next value, wrapping n-1 to 0.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] n);
    logic [31:0] inc;
    inc = ptr + 32'd1;
    return (inc >= n) ? '0 : inc;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  localparam logic [31:0] N_CH_U = 32'(N_CH);

  logic [31:0] idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < N_CH_U; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N_CH_U) idx = idx - N_CH_U;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed or round-robin selection, locked per packet.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_src
);

  localparam logic [31:0] N_CH_U = 32'(N_CH);

  lock_state_e      state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;

  mux_mode_e        mode_e;
  logic             load;
  logic             xfer;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic [N_CH-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  assign mode_e = mux_mode_e'(mode);
  assign load   = !out_valid_q || out_ready;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // A locked packet owns the mux regardless of mode/sel until its last beat.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (state_q == ST_LOCKED) begin
      if (in_valid[lock_ch_q]) begin
        grant[lock_ch_q] = 1'b1;
        grant_idx        = lock_ch_q;
      end
    end else if (mode_e == MODE_RR) begin
      grant     = arb_gnt;
      grant_idx = arb_idx;
    end else if ((32'(sel) < N_CH_U) && in_valid[sel]) begin
      grant[sel] = 1'b1;
      grant_idx  = sel;
    end
  end

  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    for (int unsigned i = 0; i < N_CH_U; i++) begin
      if (grant[i]) begin
        beat_data = in_data[i*WIDTH +: WIDTH];
        beat_last = in_last[i];
      end
    end
  end

  assign in_ready = (rst_n && load) ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = beat_data;
        out_last_d = beat_last;
        out_src_d  = grant_idx;
        if (beat_last) begin
          state_d = ST_IDLE;
          if (mode_e == MODE_RR)
            rr_ptr_d = SEL_W'(next_ptr(32'(grant_idx), N_CH_U));
        end else begin
          state_d   = ST_LOCKED;
          lock_ch_d = grant_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, N_CH=3 corner cases, random vs model.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mode, out_ready, out_valid, out_last;
  logic [1:0]  sel, out_src;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [31:0] in_data;
  logic [7:0]  out_data;

  logic        mode3, out_ready3, out_valid3, out_last3;
  logic [1:0]  sel3, out_src3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [23:0] in_data3;
  logic [7:0]  out_data3;

  stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_last(in_last3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .out_src(out_src3)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic        exp_ol;
    logic [1:0]  exp_os;
  } vec_t;

  vec_t vecs[25];

  // Reference model: packet-level view of ownership, pointer and output register.
  bit       m_locked;
  int       m_lock_ch, m_ptr, m_os;
  bit       m_ov, m_ol;
  logic [7:0] m_od;

  function automatic int model_grant();
    if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
    if (mode) begin
      for (int k = 0; k < 4; k++) begin
        int c = (m_ptr + k) % 4;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    return in_valid[sel] ? int'(sel) : -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g = model_grant();
    if (!rst_n || (m_ov && !out_ready) || g < 0) return 4'd0;
    return 4'(1 << g);
  endfunction

  function automatic void model_edge();
    int g = model_grant();
    logic [31:0] d = in_data;
    if (!rst_n) begin
      m_locked = 0; m_lock_ch = 0; m_ptr = 0; m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    end else if (!m_ov || out_ready) begin
      if (g >= 0) begin
        m_ov = 1; m_od = d[g*8 +: 8]; m_ol = in_last[g]; m_os = g;
        if (in_last[g]) begin
          m_locked = 0;
          if (mode) m_ptr = (g + 1) % 4;
        end else begin
          m_locked = 1; m_lock_ch = g;
        end
      end else begin
        m_ov = 0;
      end
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst mode sel valid last  data           ordy  rdy   ov  od     ol  os
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 4'h4, 4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b1, 8'hA5, 1'b1, 2'd2};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 8'hA5, 1'b1, 2'd2};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h2, 1'b1, 8'h11, 1'b1, 2'd1};
    vecs[5]  = '{1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h4, 1'b1, 8'h12, 1'b1, 2'd2};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h8, 1'b1, 8'h13, 1'b1, 2'd3};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 4'h7, 4'h5, 32'h00223120, 1'b1, 4'h2, 1'b1, 8'h31, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 4'h7, 4'h5, 32'h00223220, 1'b1, 4'h2, 1'b1, 8'h32, 1'b0, 2'd1};
    vecs[10] = '{1'b1, 1'b1, 2'd0, 4'h7, 4'h7, 32'h00223320, 1'b1, 4'h2, 1'b1, 8'h33, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 4'h5, 4'h5, 32'h00220020, 1'b1, 4'h4, 1'b1, 8'h22, 1'b1, 2'd2};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 32'h00000040, 1'b0, 4'h0, 1'b1, 8'h22, 1'b1, 2'd2};
    vecs[13] = '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 32'h00000040, 1'b0, 4'h0, 1'b1, 8'h22, 1'b1, 2'd2};
    vecs[14] = '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 32'h00000040, 1'b0, 4'h0, 1'b1, 8'h22, 1'b1, 2'd2};
    vecs[15] = '{1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 32'h00000040, 1'b1, 4'h1, 1'b1, 8'h40, 1'b1, 2'd0};
    vecs[16] = '{1'b1, 1'b0, 2'd0, 4'h3, 4'h2, 32'h00005150, 1'b1, 4'h1, 1'b1, 8'h50, 1'b0, 2'd0};
    vecs[17] = '{1'b1, 1'b0, 2'd1, 4'h3, 4'h2, 32'h00005152, 1'b1, 4'h1, 1'b1, 8'h52, 1'b0, 2'd0};
    vecs[18] = '{1'b1, 1'b0, 2'd1, 4'h3, 4'h3, 32'h00005153, 1'b1, 4'h1, 1'b1, 8'h53, 1'b1, 2'd0};
    vecs[19] = '{1'b1, 1'b0, 2'd1, 4'h2, 4'h2, 32'h00005100, 1'b1, 4'h2, 1'b1, 8'h51, 1'b1, 2'd1};
    vecs[20] = '{1'b1, 1'b0, 2'd0, 4'h1, 4'h0, 32'h00000060, 1'b1, 4'h1, 1'b1, 8'h60, 1'b0, 2'd0};
    vecs[21] = '{1'b1, 1'b1, 2'd0, 4'h2, 4'h2, 32'h00006100, 1'b1, 4'h0, 1'b0, 8'h60, 1'b0, 2'd0};
    vecs[22] = '{1'b0, 1'b1, 2'd0, 4'hF, 4'h0, 32'h13121110, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[23] = '{1'b1, 1'b0, 2'd3, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h8, 1'b1, 8'h13, 1'b1, 2'd3};
    vecs[24] = '{1'b1, 1'b1, 2'd3, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0};

    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = '0; in_valid3 = '0; in_last3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; mode = vecs[i].mode; sel = vecs[i].sel;
      in_valid = vecs[i].valid; in_last = vecs[i].last; in_data = vecs[i].data;
      out_ready = vecs[i].ordy;
      #3;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
      check($sformatf("v%0d out_last", i), 32'(out_last), 32'(vecs[i].exp_ol));
      check($sformatf("v%0d out_src", i), 32'(out_src), 32'(vecs[i].exp_os));
    end

    // N_CH=3: out-of-range select grants nothing; RR wraps 2 -> 0.
    in_valid = '0;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111; in_data3 = 24'h222120;
    #3;
    check("n3 sel_oob in_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    check("n3 sel_oob out_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #3;
    check("n3 sel2 in_ready", 32'(in_ready3), 32'h4);
    @(posedge clk); #1;
    check("n3 sel2 out_data", 32'(out_data3), 32'h22);
    check("n3 sel2 out_src", 32'(out_src3), 32'd2);
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("n3 rr%0d out_src", k), 32'(out_src3), 32'(k % 3));
      check($sformatf("n3 rr%0d out_valid", k), 32'(out_valid3), 32'd1);
    end
    in_valid3 = '0;

    // Random phase against the reference model, starting from a reset cycle.
    for (int c = 0; c < 2000; c++) begin
      rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #3;
      check("rand in_ready", 32'(in_ready), 32'(model_ready()));
      @(posedge clk);
      model_edge();
      #1;
      check("rand out_valid", 32'(out_valid), 32'(m_ov));
      check("rand out_data", 32'(out_data), 32'(m_od));
      check("rand out_last", 32'(out_last), 32'(m_ol));
      check("rand out_src", 32'(out_src), 32'(m_os));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
